// File: rtl/prl_tx_arb_if.sv
// Signal bundle between the PHY TX arbiter, its three protocol-layer requesters and the PHY TX port.
// Handshakes: a requester holds req_en until its one-cycle req_done; a payload byte stays valid until the PHY pulses phy2prl_tx_payload_done for it.
interface prl_tx_arb_if;
    logic [2:0]  req_en;
    logic [8:0]  req_type;
    logic [2:0]  req_payload_en;
    logic [23:0] req_payload;
    logic [2:0]  req_payload_last;
    logic [2:0]  req_payload_done;
    logic [2:0]  req_done;
    logic [2:0]  req_result;
    logic [2:0]  grant;

    logic        prl2phy_tx_packet_en;
    logic [2:0]  prl2phy_tx_packet_type;
    logic        phy2prl_tx_packet_done;
    logic        phy2prl_tx_packet_result;
    logic        prl2phy_tx_payload_en;
    logic [7:0]  prl2phy_tx_payload;
    logic        prl2phy_tx_payload_last;
    logic        phy2prl_tx_payload_done;
    logic        phy_rx_busy;

    // Arbiter side.
    modport master (
        input  req_en, req_type, req_payload_en, req_payload, req_payload_last,
        input  phy2prl_tx_packet_done, phy2prl_tx_packet_result,
        input  phy2prl_tx_payload_done, phy_rx_busy,
        output req_payload_done, req_done, req_result, grant,
        output prl2phy_tx_packet_en, prl2phy_tx_packet_type,
        output prl2phy_tx_payload_en, prl2phy_tx_payload, prl2phy_tx_payload_last
    );

    // Requesters plus PHY side.
    modport slave (
        output req_en, req_type, req_payload_en, req_payload, req_payload_last,
        output phy2prl_tx_packet_done, phy2prl_tx_packet_result,
        output phy2prl_tx_payload_done, phy_rx_busy,
        input  req_payload_done, req_done, req_result, grant,
        input  prl2phy_tx_packet_en, prl2phy_tx_packet_type,
        input  prl2phy_tx_payload_en, prl2phy_tx_payload, prl2phy_tx_payload_last
    );
endinterface

// File: rtl/prl_tx_arb.sv
// Fixed-priority arbiter/sequencer for the single PHY TX channel: hard reset > GoodCRC > message.
// One packet at a time, inter-frame gap after every packet end, watchdog abort on a stuck PHY.
module prl_tx_arb #(
    parameter int IFG_CYCLES     = 300,
    parameter int TIMEOUT_CYCLES = 12000,
    parameter int CW             = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    prl_tx_arb_if.master bus,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [CW-1:0] IFG_LOAD = CW'(IFG_CYCLES);
    localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYCLES);

    state_t        state;
    logic [1:0]    owner;
    logic [2:0]    owner_oh;
    logic [CW-1:0] wdog;
    logic [CW-1:0] gap_cnt;
    logic [2:0]    grant_r;
    logic [2:0]    type_r;
    logic          packet_en_r;
    logic [2:0]    req_done_r;
    logic [2:0]    req_result_r;

    logic [1:0]    win_idx;
    logic [2:0]    win_oh;
    logic [2:0]    win_type;

    // Lowest set index wins.
    always_comb begin
        win_idx  = 2'd0;
        win_type = bus.req_type[2:0];
        if (bus.req_en[0]) begin
            win_idx  = 2'd0;
            win_type = bus.req_type[2:0];
        end else if (bus.req_en[1]) begin
            win_idx  = 2'd1;
            win_type = bus.req_type[5:3];
        end else begin
            win_idx  = 2'd2;
            win_type = bus.req_type[8:6];
        end
    end

    assign win_oh   = 3'b001 << win_idx;
    assign owner_oh = 3'b001 << owner;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= 2'd0;
            wdog         <= '0;
            gap_cnt      <= '0;
            grant_r      <= 3'b000;
            type_r       <= 3'b000;
            packet_en_r  <= 1'b0;
            req_done_r   <= 3'b000;
            req_result_r <= 3'b000;
        end else begin
            packet_en_r  <= 1'b0;
            req_done_r   <= 3'b000;
            req_result_r <= 3'b000;
            case (state)
                IDLE: begin
                    if ((|bus.req_en) && !bus.phy_rx_busy) begin
                        state       <= START;
                        owner       <= win_idx;
                        type_r      <= win_type;
                        grant_r     <= win_oh;
                        packet_en_r <= 1'b1;
                    end
                end
                START: begin
                    wdog  <= TO_LOAD;
                    state <= BUSY;
                end
                BUSY: begin
                    // A PHY done in the expiry cycle still reports the PHY result.
                    if (bus.phy2prl_tx_packet_done) begin
                        req_done_r   <= owner_oh;
                        req_result_r <= bus.phy2prl_tx_packet_result ? owner_oh : 3'b000;
                        grant_r      <= 3'b000;
                        type_r       <= 3'b000;
                        wdog         <= '0;
                        gap_cnt      <= IFG_LOAD;
                        state        <= GAP;
                    end else if (wdog <= CW'(1)) begin
                        req_done_r   <= owner_oh;
                        grant_r      <= 3'b000;
                        type_r       <= 3'b000;
                        wdog         <= '0;
                        gap_cnt      <= IFG_LOAD;
                        state        <= GAP;
                    end else begin
                        wdog <= wdog - CW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt <= CW'(1)) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload path is a pure mux on the owner, live only while the packet is in flight.
    always_comb begin
        bus.prl2phy_tx_payload_en   = 1'b0;
        bus.prl2phy_tx_payload      = 8'h00;
        bus.prl2phy_tx_payload_last = 1'b0;
        bus.req_payload_done        = 3'b000;
        if (state == BUSY) begin
            bus.req_payload_done = bus.phy2prl_tx_payload_done ? owner_oh : 3'b000;
            case (owner)
                2'd0: begin
                    bus.prl2phy_tx_payload_en   = bus.req_payload_en[0];
                    bus.prl2phy_tx_payload      = bus.req_payload[7:0];
                    bus.prl2phy_tx_payload_last = bus.req_payload_last[0];
                end
                2'd1: begin
                    bus.prl2phy_tx_payload_en   = bus.req_payload_en[1];
                    bus.prl2phy_tx_payload      = bus.req_payload[15:8];
                    bus.prl2phy_tx_payload_last = bus.req_payload_last[1];
                end
                2'd2: begin
                    bus.prl2phy_tx_payload_en   = bus.req_payload_en[2];
                    bus.prl2phy_tx_payload      = bus.req_payload[23:16];
                    bus.prl2phy_tx_payload_last = bus.req_payload_last[2];
                end
                default: ;
            endcase
        end
    end

    assign bus.grant                  = grant_r;
    assign bus.req_done               = req_done_r;
    assign bus.req_result             = req_result_r;
    assign bus.prl2phy_tx_packet_en   = packet_en_r;
    assign bus.prl2phy_tx_packet_type = type_r;
    assign dbg_state                  = state;
endmodule

// File: tb/tb_prl_tx_arb.sv
// Self-checking bench for prl_tx_arb: directed scenarios plus randomized request mixes
// checked against a priority/timing model built from queues and cycle arithmetic.
module tb_prl_tx_arb;
    localparam int IFG = 10;
    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    prl_tx_arb_if bus ();

    prl_tx_arb #(
        .IFG_CYCLES(IFG),
        .TIMEOUT_CYCLES(TMO),
        .CW(14)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail = 0;
    int n_pkt_en = 0;
    int n_done = 0;
    int exp_pkts = 0;
    int exp_dones = 0;
    int last_done_cyc = 0;
    int last_start_cyc = 0;

    logic [2:0] exp_q[$];
    logic [2:0] exp_type[3];

    always @(negedge clk) begin
        if (bus.prl2phy_tx_packet_en) n_pkt_en++;
        if (|bus.req_done) n_done++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 50000 cycles");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_en                   = 3'b000;
        bus.req_type                 = 9'h000;
        bus.req_payload_en           = 3'b000;
        bus.req_payload              = 24'h000000;
        bus.req_payload_last         = 3'b000;
        bus.phy2prl_tx_packet_done   = 1'b0;
        bus.phy2prl_tx_packet_result = 1'b0;
        bus.phy2prl_tx_payload_done  = 1'b0;
        bus.phy_rx_busy              = 1'b0;
    endtask

    task automatic set_type(input int idx, input logic [2:0] t);
        bus.req_type[3*idx +: 3] = t;
        exp_type[idx] = t;
    endtask

    function automatic int idx_of(input logic [2:0] oh);
        for (int i = 0; i < 3; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_grant"}, bus.grant, 0);
        check({tag, "_req_done"}, bus.req_done, 0);
        check({tag, "_req_result"}, bus.req_result, 0);
        check({tag, "_pl_done"}, bus.req_payload_done, 0);
        check({tag, "_pkt_en"}, bus.prl2phy_tx_packet_en, 0);
        check({tag, "_pkt_type"}, bus.prl2phy_tx_packet_type, 0);
        check({tag, "_pl_en"}, bus.prl2phy_tx_payload_en, 0);
        check({tag, "_pl_byte"}, bus.prl2phy_tx_payload, 0);
        check({tag, "_pl_last"}, bus.prl2phy_tx_payload_last, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    task automatic wait_start(input int budget, output int waited);
        waited = 0;
        while (!bus.prl2phy_tx_packet_en && waited < budget) begin
            tick();
            waited++;
        end
        if (!bus.prl2phy_tx_packet_en) check("start_timeout", 0, 1);
    endtask

    // Called in the START cycle; streams payload, ends the packet with a PHY done.
    task automatic serve_packet(input logic [31:0] bytes, input int nbytes, input logic result,
                                input int lat, input logic [2:0] raise);
        logic [2:0] exp_g;
        logic [7:0] b;
        logic       lst;
        int         idx;
        exp_pkts++;
        exp_dones++;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
            exp_g = 3'b001;
        end else begin
            exp_g = exp_q.pop_front();
        end
        idx = idx_of(exp_g);
        check("start_pulse", bus.prl2phy_tx_packet_en, 1);
        check("grant", bus.grant, exp_g);
        check("pkt_type", bus.prl2phy_tx_packet_type, exp_type[idx]);
        tick();
        check("start_one_cycle", bus.prl2phy_tx_packet_en, 0);
        check("busy_state", dbg_state, 2);
        bus.req_en      = bus.req_en | raise;
        bus.phy_rx_busy = 1'($urandom_range(0, 1));
        for (int k = 0; k < nbytes; k++) begin
            b   = bytes[8*k +: 8];
            lst = (k == nbytes - 1);
            bus.req_payload_en   = 3'($urandom_range(0, 7));
            bus.req_payload      = 24'($urandom);
            bus.req_payload_last = 3'($urandom_range(0, 7));
            bus.req_payload_en[idx]       = 1'b1;
            bus.req_payload[8*idx +: 8]   = b;
            bus.req_payload_last[idx]     = lst;
            bus.phy2prl_tx_payload_done   = 1'b1;
            #1;
            check("pl_en", bus.prl2phy_tx_payload_en, 1);
            check("pl_byte", bus.prl2phy_tx_payload, b);
            check("pl_last", bus.prl2phy_tx_payload_last, lst);
            check("pl_done_route", bus.req_payload_done, exp_g);
            check("grant_held", bus.grant, exp_g);
            tick();
        end
        bus.req_payload_en          = 3'b000;
        bus.req_payload             = 24'h000000;
        bus.req_payload_last        = 3'b000;
        bus.phy2prl_tx_payload_done = 1'b0;
        repeat (lat) begin
            tick();
            check("no_early_done", bus.req_done, 0);
        end
        bus.phy2prl_tx_packet_done   = 1'b1;
        bus.phy2prl_tx_packet_result = result;
        tick();
        bus.phy2prl_tx_packet_done   = 1'b0;
        bus.phy2prl_tx_packet_result = 1'b0;
        bus.phy_rx_busy              = 1'b0;
        check("req_done", bus.req_done, exp_g);
        check("req_result", bus.req_result, result ? exp_g : 3'b000);
        check("grant_clear", bus.grant, 0);
        check("gap_state", dbg_state, 3);
        last_done_cyc = cyc;
        bus.req_en = bus.req_en & ~exp_g;
    endtask

    // All requesters in mask raise together from IDLE; model: served in ascending index order.
    task automatic run_group(input logic [2:0] mask);
        int waited;
        int gap;
        for (int i = 0; i < 3; i++) begin
            set_type(i, 3'($urandom_range(0, 7)));
            if (mask[i]) exp_q.push_back(3'(1 << i));
        end
        bus.req_en = mask;
        for (int p = 0; p < 3 && exp_q.size() > 0; p++) begin
            wait_start(IFG + 10, waited);
            if (p == 0) begin
                check("req_to_start", waited, 1);
            end else begin
                gap = cyc - last_done_cyc;
                check("ifg_min", gap >= IFG, 1);
                check("ifg_max", gap <= IFG + 2, 1);
                check("start_spacing", (cyc - last_start_cyc) >= IFG + 2, 1);
            end
            last_start_cyc = cyc;
            serve_packet($urandom, $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 6), 3'b000);
        end
        repeat (IFG + 3) tick();
    endtask

    initial begin
        int waited;
        int n;
        int cnt;
        idle_inputs();

        // Reset state.
        repeat (3) tick();
        check_quiet("reset");
        rst_n = 1'b1;
        tick();

        // Single message with fixed payload.
        set_type(2, 3'd0);
        exp_q.push_back(3'b100);
        bus.req_en = 3'b100;
        wait_start(IFG + 10, waited);
        check("single_latency", waited, 1);
        serve_packet(32'h0000_5CA1, 2, 1'b1, 2, 3'b000);

        // PHY done outside BUSY is ignored, in GAP and in IDLE.
        bus.phy2prl_tx_packet_done   = 1'b1;
        bus.phy2prl_tx_packet_result = 1'b1;
        tick();
        bus.phy2prl_tx_packet_done   = 1'b0;
        check("done_in_gap_ignored", bus.req_done, 0);
        check("gap_holds", dbg_state, 3);
        repeat (IFG + 3) tick();
        bus.phy2prl_tx_packet_done = 1'b1;
        tick();
        bus.phy2prl_tx_packet_done   = 1'b0;
        bus.phy2prl_tx_packet_result = 1'b0;
        check("done_in_idle_ignored", bus.req_done, 0);
        check("idle_holds", dbg_state, 0);

        // Simultaneous requests, then random mixes.
        run_group(3'b111);
        for (int g = 0; g < 6; g++) run_group(3'($urandom_range(1, 7)));

        // Rx deferral.
        set_type(1, 3'd4);
        exp_q.push_back(3'b010);
        bus.phy_rx_busy = 1'b1;
        bus.req_en      = 3'b010;
        cnt = 0;
        repeat (50) begin
            tick();
            if (bus.prl2phy_tx_packet_en) cnt++;
        end
        check("rx_defer", cnt, 0);
        bus.phy_rx_busy = 1'b0;
        tick();
        check("rx_release_start", bus.prl2phy_tx_packet_en, 1);
        serve_packet($urandom, 3, 1'b1, 1, 3'b000);
        repeat (IFG + 3) tick();

        // Hard reset arriving mid-message waits for the message to end.
        set_type(2, 3'd3);
        set_type(0, 3'd7);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b001);
        bus.req_en = 3'b100;
        wait_start(IFG + 10, waited);
        last_start_cyc = cyc;
        serve_packet($urandom, 4, 1'b1, 3, 3'b001);
        wait_start(IFG + 10, waited);
        check("hr_after_gap_min", (cyc - last_done_cyc) >= IFG, 1);
        serve_packet($urandom, 1, 1'b0, 0, 3'b000);
        repeat (IFG + 3) tick();

        // Watchdog abort.
        set_type(1, 3'd5);
        bus.req_en = 3'b010;
        wait_start(IFG + 10, waited);
        exp_pkts++;
        exp_dones++;
        check("wdog_grant", bus.grant, 3'b010);
        check("wdog_type", bus.prl2phy_tx_packet_type, 3'd5);
        n = 0;
        while (bus.req_done == 3'b000 && n < 3 * TMO) begin
            tick();
            n++;
        end
        check("wdog_latency", n, TMO + 1);
        check("wdog_done", bus.req_done, 3'b010);
        check("wdog_result", bus.req_result, 0);
        check("wdog_gap", dbg_state, 3);
        check("wdog_grant_clear", bus.grant, 0);
        bus.req_en = 3'b000;
        repeat (IFG + 3) tick();

        // PHY done lands in the expiry cycle: the PHY result is reported.
        set_type(0, 3'd2);
        bus.req_en = 3'b001;
        wait_start(IFG + 10, waited);
        exp_pkts++;
        exp_dones++;
        repeat (TMO) tick();
        bus.phy2prl_tx_packet_done   = 1'b1;
        bus.phy2prl_tx_packet_result = 1'b1;
        tick();
        bus.phy2prl_tx_packet_done   = 1'b0;
        bus.phy2prl_tx_packet_result = 1'b0;
        check("race_done", bus.req_done, 3'b001);
        check("race_result", bus.req_result, 3'b001);
        bus.req_en = 3'b000;
        tick();
        check("race_single_pulse", bus.req_done, 0);
        check("race_gap", dbg_state, 3);
        repeat (IFG + 3) tick();

        // Reset mid-BUSY, then re-arbitration of the still-pending request.
        set_type(2, 3'd6);
        bus.req_en = 3'b100;
        wait_start(IFG + 10, waited);
        exp_pkts++;
        tick();
        bus.req_payload_en[2]       = 1'b1;
        bus.req_payload[23:16]      = 8'h3C;
        bus.phy2prl_tx_payload_done = 1'b1;
        rst_n = 1'b0;
        tick();
        check_quiet("midrst");
        rst_n = 1'b1;
        bus.req_payload_en          = 3'b000;
        bus.req_payload             = 24'h000000;
        bus.phy2prl_tx_payload_done = 1'b0;
        tick();
        exp_q.push_back(3'b100);
        serve_packet($urandom, 2, 1'b1, 1, 3'b000);
        repeat (IFG + 3) tick();

        check("pkt_en_total", n_pkt_en, exp_pkts);
        check("done_total", n_done, exp_dones);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
